// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
//
// Stage 1 (S1) captures {a, b, opcode} on an accepted operation.
// Stage 2 (S2) computes the result and registers {y, flags}.
// Results leave in issue order, at one operation per cycle when the consumer keeps up.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (a, b, opcode)
//   out_valid/out_ready : result handshake (y, zero, carry, overflow, negative)
//   sticky_ovf          : set by any transferred result with overflow=1
//   clr_sticky          : clears sticky_ovf; a same-cycle set takes priority
//
// Optional feature: define ALU_MUL_EN to add an unsigned iterative shift-add
// multiplier on opcode 1111. Without it, opcode 1111 returns y=0 with the
// normal two-cycle latency.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTS = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MOVA = 4'b1011;
    localparam logic [3:0] OP_MOVB = 4'b1100;
    localparam logic [3:0] OP_ROL  = 4'b1101;
    localparam logic [3:0] OP_ROR  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             sticky_q, sticky_d;

    logic s2_free, mul_idle, s1_is_mul, advance, accept, out_xfer;

    logic [SHW-1:0]     sh_amt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] rol_ext;
    logic [2*WIDTH-1:0] ror_ext;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_carry;
    logic               alu_ovf;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    mul_state_t         mul_state_q, mul_state_d;
    logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d;
    logic [2*WIDTH-1:0] mul_mcand_q, mul_mcand_d;
    logic [WIDTH-1:0]   mul_mplier_q, mul_mplier_d;
    logic [SHW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [2*WIDTH-1:0] mul_acc_next;

    assign mul_idle  = (mul_state_q == MUL_IDLE);
    assign s1_is_mul = (s1_op_q == OP_MUL);
`else
    assign mul_idle  = 1'b1;
    assign s1_is_mul = 1'b0;
`endif

    // S2 can take a new result once its current one is gone or leaving now.
    assign s2_free  = !out_valid_q || out_ready;
    assign advance  = s1_valid_q && s2_free && mul_idle;
    assign in_ready = !rst && (!s1_valid_q || (s2_free && mul_idle));
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Rotates take the matching half of the doubled operand, so a zero
    // shift amount naturally passes a through.
    always_comb begin
        sh_amt    = s1_b_q[SHW-1:0];
        sum_ext   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff      = s1_a_q - s1_b_q;
        rol_ext   = {s1_a_q, s1_a_q} << sh_amt;
        ror_ext   = {s1_a_q, s1_a_q} >> sh_amt;
        alu_y     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_y     = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y     = diff;
                alu_carry = (s1_a_q >= s1_b_q);
                alu_ovf   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                            (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND:  alu_y = s1_a_q & s1_b_q;
            OP_OR:   alu_y = s1_a_q | s1_b_q;
            OP_XOR:  alu_y = s1_a_q ^ s1_b_q;
            OP_NOR:  alu_y = ~(s1_a_q | s1_b_q);
            OP_SLL:  alu_y = s1_a_q << sh_amt;
            OP_SRL:  alu_y = s1_a_q >> sh_amt;
            OP_SRA:  alu_y = $signed(s1_a_q) >>> sh_amt;
            OP_SLTS: alu_y[0] = ($signed(s1_a_q) < $signed(s1_b_q));
            OP_SLTU: alu_y[0] = (s1_a_q < s1_b_q);
            OP_MOVA: alu_y = s1_a_q;
            OP_MOVB: alu_y = s1_b_q;
            OP_ROL:  alu_y = rol_ext[2*WIDTH-1:WIDTH];
            OP_ROR:  alu_y = ror_ext[WIDTH-1:0];
            OP_MUL:  alu_y = '0;
            default: alu_y = '0;
        endcase
    end

    // Next-state for both stages, the sticky flag and the multiplier FSM.
    // A multiply leaves S1 into the FSM instead of directly into the result
    // registers; it only writes them on the final partial product.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        sticky_d    = sticky_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = opcode;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (advance && !s1_is_mul) begin
            out_valid_d = 1'b1;
            y_d         = alu_y;
            zero_d      = (alu_y == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            neg_d       = alu_y[WIDTH-1];
        end

`ifdef ALU_MUL_EN
        mul_state_d  = mul_state_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        mul_acc_next = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
        case (mul_state_q)
            MUL_IDLE: begin
                if (advance && s1_is_mul) begin
                    mul_state_d  = MUL_BUSY;
                    mul_acc_d    = '0;
                    mul_mcand_d  = {{WIDTH{1'b0}}, s1_a_q};
                    mul_mplier_d = s1_b_q;
                    mul_cnt_d    = '0;
                end
            end
            MUL_BUSY: begin
                mul_acc_d    = mul_acc_next;
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                mul_cnt_d    = mul_cnt_q + 1'b1;
                if (mul_cnt_q == SHW'(WIDTH - 1)) begin
                    mul_state_d = MUL_DONE;
                    out_valid_d = 1'b1;
                    y_d         = mul_acc_next[WIDTH-1:0];
                    zero_d      = (mul_acc_next[WIDTH-1:0] == '0);
                    carry_d     = (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
                    ovf_d       = 1'b0;
                    neg_d       = mul_acc_next[WIDTH-1];
                end
            end
            MUL_DONE: begin
                if (out_xfer) begin
                    mul_state_d = MUL_IDLE;
                end
            end
            default: mul_state_d = MUL_IDLE;
        endcase
`endif

        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (out_xfer && ovf_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            sticky_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mul_state_q  <= MUL_IDLE;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            sticky_q    <= sticky_d;
`ifdef ALU_MUL_EN
            mul_state_q  <= mul_state_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign y          = y_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign overflow   = ovf_q;
    assign negative   = neg_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational ALU. Operand width is set by WIDTH. Operations are accepted over a valid/ready handshake and results are returned two cycles later with registered flags. Adds rotate operations, a sticky overflow flag and an optional iterative multiplier. Sits between the operand-issue logic and the writeback path of the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..64, power of two.
SHW (localparam), $clog2(WIDTH), shift-amount width; shift amount is b[SHW-1:0].

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  4  operation selector
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
zero  output  1  y == 0
carry  output  1  carry/no-borrow (ADD/SUB/MUL only, else 0)
overflow  output  1  signed overflow (ADD/SUB only, else 0)
negative  output  1  y[WIDTH-1]
sticky_ovf  output  1  latched overflow since last clear
clr_sticky  input  1  clear sticky_ovf

Behaviour:
- Reset: at a clock edge with rst=1, s1_valid, out_valid, y and all flags go to 0, sticky_ovf goes to 0, and any multiply in progress is aborted. in_ready=0 while rst=1.
- Pipeline:
  - S1 registers {a, b, opcode}. S2 computes and registers {y, flags}.
  - Accept occurs when in_valid & in_ready. out_valid rises 2 cycles after accept (non-MUL ops).
  - Throughput is 1 op/cycle. Order is preserved.
  - Stage advance: s2_free = !out_valid | out_ready. s1 moves to s2 when s1_valid & s2_free (and multiplier idle).
  - in_ready = !s1_valid | (s2_free & mul idle).
  - While out_valid=1 and out_ready=0, y and all flags hold stable. No data is dropped or duplicated.
- Opcodes:
  - 0000 ADD: carry = carry out of bit WIDTH-1. overflow = a,b same sign & y sign differs.
  - 0001 SUB: carry = 1 when a >= b unsigned (no borrow). overflow = a,b signs differ & y sign differs from a.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
  - 0110 SLL, 0111 SRL, 1000 SRA (sign fill), 1101 ROL, 1110 ROR: all by b[SHW-1:0]. A shift amount of 0 passes a through unchanged.
  - 1001 SLT signed, 1010 SLT unsigned: y = 1 or 0.
  - 1011 MOVA, 1100 MOVB.
  - 1111 MUL: see Optional Feature.
- Flags: zero and negative are derived from the final y for every op. carry and overflow are 0 for every op except as listed above.
- Sticky: sticky_ovf sets on any output transfer (out_valid & out_ready) with overflow=1. clr_sticky clears it. If set and clear occur in the same cycle, set wins.

Optional Feature:
Macro ALU_MUL_EN.
- Defined:
  - Opcode 1111 is an unsigned iterative shift-add multiply in S2, using FSM IDLE -> BUSY (WIDTH cycles, one partial product per cycle) -> DONE.
  - DONE asserts out_valid. The FSM returns to IDLE on the output transfer.
  - While BUSY or DONE, S2 does not accept from S1; S1 may still fill once, then in_ready=0.
  - y = low WIDTH bits of the product. carry = 1 if the high WIDTH bits are nonzero. overflow = 0.
  - Accept-to-out_valid latency is WIDTH+2 cycles.
  - Reset during BUSY discards the operation.
- Undefined:
  - Opcode 1111 behaves as an undefined opcode: y=0, zero=1, other flags 0, latency 2. No multiplier logic is instantiated.

Test Plan:
- ADD, WIDTH=16: a=0x7FFF, b=0x0001 -> y=0x8000, overflow=1, negative=1, carry=0, zero=0; out_valid exactly 2 cycles after accept; sticky_ovf=1 after the transfer.
- SUB: a=0x0003, b=0x0005 -> y=0xFFFE, carry=0, overflow=0. Then a=0x0005, b=0x0005 -> y=0, zero=1, carry=1.
- Backpressure: 4 back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts; after out_ready=1, all 4 results emerge in order with no loss or duplication.
- WIDTH=32: SRA a=0x80000000, b=31 -> y=0xFFFFFFFF. WIDTH=16: ROL a=0x8001, b=1 -> y=0x0003; ROR a=0x0001, b=1 -> y=0x8000.
- Sticky: clr_sticky asserted in the same cycle as an overflowing output transfer -> sticky_ovf=1. clr_sticky alone in the next cycle -> sticky_ovf=0.
- ALU_MUL_EN, WIDTH=16: a=0x0100, b=0x0100 -> y=0x0000, carry=1, zero=1 after 18 cycles. Then a=0x00FF, b=0x0002 -> y=0x01FE, carry=0. rst asserted mid-BUSY -> out_valid=0 and no result is produced.
